// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/func
// fields, ALU operation codes and datapath mux selects.
package mccu_pkg;

   localparam logic [2:0] S_IF  = 3'b000;
   localparam logic [2:0] S_ID  = 3'b001;
   localparam logic [2:0] S_EXE = 3'b010;
   localparam logic [2:0] S_MEM = 3'b011;
   localparam logic [2:0] S_WB  = 3'b100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;
   localparam logic [3:0] ALUC_SLT = 4'b1011;

   localparam logic [1:0] SRCB_REGB   = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REGA   = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   // One-hot instruction class; all-zero means unsupported.
   typedef struct packed {
      logic r_alu;
      logic shift;
      logic jr;
      logic i_alu;
      logic lw;
      logic sw;
      logic beq;
      logic bne;
      logic j;
      logic jal;
   } iclass_t;

   function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] func);
      logic [3:0] c;
      c = ALUC_ADD;
      if (op == OP_RTYPE) begin
         case (func)
            FN_SUB:  c = ALUC_SUB;
            FN_AND:  c = ALUC_AND;
            FN_OR:   c = ALUC_OR;
            FN_XOR:  c = ALUC_XOR;
            FN_SLL:  c = ALUC_SLL;
            FN_SRL:  c = ALUC_SRL;
            FN_SRA:  c = ALUC_SRA;
            FN_SLT:  c = ALUC_SLT;
            default: c = ALUC_ADD;
         endcase
      end else begin
         case (op)
            OP_ANDI: c = ALUC_AND;
            OP_ORI:  c = ALUC_OR;
            OP_XORI: c = ALUC_XOR;
            OP_LUI:  c = ALUC_LUI;
            default: c = ALUC_ADD;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/mccu_decode.sv
// Instruction classifier: maps opcode/func to a one-hot class and flags
// encodings the control unit does not implement.
module mccu_decode import mccu_pkg::*; #(
   parameter int HAS_SLT = 0
) (
   input  logic [5:0] op,
   input  logic [5:0] func,
   output iclass_t    cls,
   output logic       illegal
);

   always_comb begin
      cls = '0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: cls.r_alu = 1'b1;
               FN_SLL, FN_SRL, FN_SRA:                cls.shift = 1'b1;
               FN_JR:                                 cls.jr    = 1'b1;
               FN_SLT:                                cls.r_alu = (HAS_SLT != 0);
               default: ;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls.i_alu = 1'b1;
         OP_LW:   cls.lw  = 1'b1;
         OP_SW:   cls.sw  = 1'b1;
         OP_BEQ:  cls.beq = 1'b1;
         OP_BNE:  cls.bne = 1'b1;
         OP_J:    cls.j   = 1'b1;
         OP_JAL:  cls.jal = 1'b1;
         default: ;
      endcase
      illegal = (cls == '0);
   end

endmodule

// File: rtl/mccu_fsm.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencer with
// combinational datapath controls derived from state and decoded class.
module mccu_fsm import mccu_pkg::*; #(
   parameter int USE_MEM_READY = 1,
   parameter int HAS_SLT       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic       alusrca,
   output logic       shift,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsrc,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic       sext,
   output logic       illegal,
   output logic [2:0] state
);

   iclass_t    cls;
   logic       dec_illegal;
   logic       ready;
   logic [2:0] state_q, state_d;
   logic       wpc_c, wir_c, wmem_c, wreg_c;

   mccu_decode #(.HAS_SLT(HAS_SLT)) u_decode (
      .op      (op),
      .func    (func),
      .cls     (cls),
      .illegal (dec_illegal)
   );

   assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = S_IF;
      wpc_c   = 1'b0;
      wir_c   = 1'b0;
      wmem_c  = 1'b0;
      wreg_c  = 1'b0;
      iord    = 1'b0;
      alusrca = 1'b0;
      shift   = 1'b0;
      alusrcb = SRCB_REGB;
      aluc    = ALUC_ADD;
      pcsrc   = PC_ALU;
      regrt   = 1'b0;
      m2reg   = 1'b0;
      jal     = 1'b0;
      sext    = 1'b0;
      illegal = 1'b0;
      case (state_q)
         S_IF: begin
            alusrcb = SRCB_FOUR;
            wpc_c   = ready;
            wir_c   = ready;
            state_d = ready ? S_ID : S_IF;
         end
         S_ID: begin
            if (cls.j || cls.jal) begin
               pcsrc  = PC_JUMP;
               wpc_c  = 1'b1;
               wreg_c = cls.jal;
               jal    = cls.jal;
            end else if (cls.jr) begin
               pcsrc = PC_REGA;
               wpc_c = 1'b1;
            end else if (dec_illegal) begin
               illegal = 1'b1;
            end else begin
               // Precompute the branch target into the ALU register.
               alusrcb = SRCB_BRANCH;
               sext    = 1'b1;
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (cls.beq || cls.bne) begin
               alusrca = 1'b1;
               aluc    = ALUC_SUB;
               pcsrc   = PC_BRANCH;
               wpc_c   = cls.beq ? z : ~z;
               sext    = 1'b1;
            end else if (cls.lw || cls.sw) begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
               sext    = 1'b1;
               state_d = S_MEM;
            end else if (cls.r_alu || cls.shift) begin
               alusrca = 1'b1;
               shift   = cls.shift;
               aluc    = alu_code(op, func);
               state_d = S_WB;
            end else if (cls.i_alu) begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
               sext    = (op == OP_ADDI);
               aluc    = alu_code(op, func);
               state_d = S_WB;
            end
         end
         S_MEM: begin
            iord = 1'b1;
            if (cls.sw) begin
               wmem_c  = ready;
               state_d = ready ? S_IF : S_MEM;
            end else if (cls.lw) begin
               state_d = ready ? S_WB : S_MEM;
            end
         end
         S_WB: begin
            wreg_c = 1'b1;
            regrt  = cls.i_alu || cls.lw;
            m2reg  = cls.lw;
         end
         default: ;
      endcase
   end

   // Reset overrides every write enable in the cycle it is sampled.
   assign wpc   = wpc_c  & ~rst;
   assign wir   = wir_c  & ~rst;
   assign wmem  = wmem_c & ~rst;
   assign wreg  = wreg_c & ~rst;
   assign state = state_q;

endmodule

// File: tb/tb_mccu_fsm.sv
// Randomized scoreboard bench for mccu_fsm: a per-instruction reference model
// queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_mccu_fsm;

   typedef enum {K_R, K_SH, K_JR, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] func;
      kind_t      k;
      logic [3:0] aluc;
   } ins_t;

   typedef struct packed {
      logic [2:0] state;
      logic       wpc, wir, wmem, wreg, iord, alusrca, shift;
      logic [1:0] alusrcb;
      logic [3:0] aluc;
      logic [1:0] pcsrc;
      logic       regrt, m2reg, jal, sext, illegal;
   } out_t;

   typedef struct {
      logic rst;
      logic mr;
      logic z;
      out_t exp;
   } step_t;

   typedef struct {
      bit   s;
      out_t exp;
   } sb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, z, mem_ready;
   logic [5:0] op, func;
   logic       wpc, wir, wmem, wreg, iord, alusrca, shift, regrt, m2reg, jal, sext, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] aluc;
   logic [2:0] state;

   logic       rst2, z2, mem_ready2;
   logic [5:0] op2, func2;
   logic       wpc2, wir2, wmem2, wreg2, iord2, alusrca2, shift2, regrt2, m2reg2, jal2, sext2, illegal2;
   logic [1:0] alusrcb2, pcsrc2;
   logic [3:0] aluc2;
   logic [2:0] state2;

   mccu_fsm dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
      .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .alusrca(alusrca),
      .shift(shift), .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc), .regrt(regrt),
      .m2reg(m2reg), .jal(jal), .sext(sext), .illegal(illegal), .state(state)
   );

   mccu_fsm #(.USE_MEM_READY(0), .HAS_SLT(1)) dut2 (
      .clk(clk), .rst(rst2), .op(op2), .func(func2), .z(z2), .mem_ready(mem_ready2),
      .wpc(wpc2), .wir(wir2), .wmem(wmem2), .wreg(wreg2), .iord(iord2), .alusrca(alusrca2),
      .shift(shift2), .alusrcb(alusrcb2), .aluc(aluc2), .pcsrc(pcsrc2), .regrt(regrt2),
      .m2reg(m2reg2), .jal(jal2), .sext(sext2), .illegal(illegal2), .state(state2)
   );

   out_t act1, act2;
   assign act1 = {state, wpc, wir, wmem, wreg, iord, alusrca, shift, alusrcb, aluc, pcsrc,
                  regrt, m2reg, jal, sext, illegal};
   assign act2 = {state2, wpc2, wir2, wmem2, wreg2, iord2, alusrca2, shift2, alusrcb2, aluc2, pcsrc2,
                  regrt2, m2reg2, jal2, sext2, illegal2};

   ins_t  tbl[$];
   step_t plan[$];
   sb_t   sb[$];
   int    checks = 0;
   int    errors = 0;

   // Monitor: one expected record per driven cycle, sampled mid-cycle.
   sb_t  mon_e;
   out_t mon_act;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e   = sb.pop_front();
         mon_act = mon_e.s ? act2 : act1;
         checks++;
         if (mon_act !== mon_e.exp) begin
            errors++;
            $display("FAIL outputs dut%0d t=%0t: got %h (state %0d) want %h (state %0d)",
                     mon_e.s ? 2 : 1, $time, mon_act, mon_act.state, mon_e.exp, mon_e.exp.state);
         end
         checks++;
         if (mon_act.wmem && mon_act.wreg) begin
            errors++;
            $display("FAIL wmem_wreg_excl dut%0d t=%0t: got wmem=%b wreg=%b want not both",
                     mon_e.s ? 2 : 1, $time, mon_act.wmem, mon_act.wreg);
         end
      end
   end

   function automatic out_t blank(input logic [2:0] st);
      out_t o;
      o = '0;
      o.state = st;
      return o;
   endfunction

   task automatic add_step(input logic r, input logic mr, input logic zv, input out_t e);
      step_t s;
      s.rst = r; s.mr = mr; s.z = zv; s.exp = e;
      plan.push_back(s);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference: cycle-by-cycle expected outputs of one instruction, given IF and
   // MEM wait counts and the zero flag.
   task automatic model(input ins_t in, input int unsigned wif, input int unsigned wm, input logic zv);
      out_t o;
      for (int unsigned i = 0; i < wif; i++) begin
         o = blank(3'd0); o.alusrcb = 2'b01;
         add_step(1'b0, 1'b0, zv, o);
      end
      o = blank(3'd0); o.alusrcb = 2'b01; o.wpc = 1'b1; o.wir = 1'b1;
      add_step(1'b0, 1'b1, zv, o);

      o = blank(3'd1);
      case (in.k)
         K_J, K_JAL: begin
            o.pcsrc = 2'b11; o.wpc = 1'b1;
            o.wreg  = (in.k == K_JAL); o.jal = (in.k == K_JAL);
            add_step(1'b0, rnd_bit(), zv, o);
            return;
         end
         K_JR: begin
            o.pcsrc = 2'b10; o.wpc = 1'b1;
            add_step(1'b0, rnd_bit(), zv, o);
            return;
         end
         K_ILL: begin
            o.illegal = 1'b1;
            add_step(1'b0, rnd_bit(), zv, o);
            return;
         end
         default: begin
            o.alusrcb = 2'b11; o.sext = 1'b1;
            add_step(1'b0, rnd_bit(), zv, o);
         end
      endcase

      o = blank(3'd2);
      o.alusrca = 1'b1;
      case (in.k)
         K_BEQ, K_BNE: begin
            o.aluc = 4'b0100; o.pcsrc = 2'b01; o.sext = 1'b1;
            o.wpc  = (in.k == K_BEQ) ? zv : !zv;
            add_step(1'b0, rnd_bit(), zv, o);
            return;
         end
         K_LW, K_SW: begin
            o.alusrcb = 2'b10; o.sext = 1'b1;
         end
         K_R, K_SH: begin
            o.shift = (in.k == K_SH); o.aluc = in.aluc;
         end
         default: begin
            o.alusrcb = 2'b10; o.aluc = in.aluc; o.sext = (in.op == 6'b001000);
         end
      endcase
      add_step(1'b0, rnd_bit(), zv, o);

      if (in.k == K_LW || in.k == K_SW) begin
         for (int unsigned i = 0; i < wm; i++) begin
            o = blank(3'd3); o.iord = 1'b1;
            add_step(1'b0, 1'b0, zv, o);
         end
         o = blank(3'd3); o.iord = 1'b1; o.wmem = (in.k == K_SW);
         add_step(1'b0, 1'b1, zv, o);
         if (in.k == K_SW) return;
      end

      o = blank(3'd4); o.wreg = 1'b1;
      o.regrt = (in.k == K_I || in.k == K_LW); o.m2reg = (in.k == K_LW);
      add_step(1'b0, rnd_bit(), zv, o);
   endtask

   task automatic run_plan(input bit s);
      step_t st;
      sb_t   e;
      while (plan.size() > 0) begin
         st = plan.pop_front();
         if (s) begin
            rst2 = st.rst; z2 = st.z; mem_ready2 = 1'b0;
         end else begin
            rst = st.rst; z = st.z; mem_ready = st.mr;
         end
         e.s = s; e.exp = st.exp;
         sb.push_back(e);
         @(posedge clk); #1;
      end
   endtask

   task automatic set_ins(input ins_t in, input bit s);
      logic [5:0] f;
      f = (in.op == 6'b000000) ? in.func : 6'($urandom);
      if (s) begin op2 = in.op; func2 = f; end
      else   begin op  = in.op; func  = f; end
   endtask

   task automatic issue(input ins_t in, input int unsigned wif, input int unsigned wm,
                        input logic zv, input bit s);
      set_ins(in, s);
      model(in, wif, wm, zv);
      run_plan(s);
   endtask

   localparam int I_ADD = 0, I_LW = 14, I_SW = 15, I_BEQ = 16, I_JAL = 19, I_ILLOP = 20, I_SLT = 21;

   initial begin
      out_t o;
      ins_t slt_ok;
      int   idx;

      tbl.push_back('{6'b000000, 6'b100000, K_R,   4'b0000}); // add
      tbl.push_back('{6'b000000, 6'b100010, K_R,   4'b0100}); // sub
      tbl.push_back('{6'b000000, 6'b100100, K_R,   4'b0001}); // and
      tbl.push_back('{6'b000000, 6'b100101, K_R,   4'b0101}); // or
      tbl.push_back('{6'b000000, 6'b100110, K_R,   4'b0010}); // xor
      tbl.push_back('{6'b000000, 6'b000000, K_SH,  4'b0011}); // sll
      tbl.push_back('{6'b000000, 6'b000010, K_SH,  4'b0111}); // srl
      tbl.push_back('{6'b000000, 6'b000011, K_SH,  4'b1111}); // sra
      tbl.push_back('{6'b000000, 6'b001000, K_JR,  4'b0000}); // jr
      tbl.push_back('{6'b001000, 6'b000000, K_I,   4'b0000}); // addi
      tbl.push_back('{6'b001100, 6'b000000, K_I,   4'b0001}); // andi
      tbl.push_back('{6'b001101, 6'b000000, K_I,   4'b0101}); // ori
      tbl.push_back('{6'b001110, 6'b000000, K_I,   4'b0010}); // xori
      tbl.push_back('{6'b001111, 6'b000000, K_I,   4'b0110}); // lui
      tbl.push_back('{6'b100011, 6'b000000, K_LW,  4'b0000}); // lw
      tbl.push_back('{6'b101011, 6'b000000, K_SW,  4'b0000}); // sw
      tbl.push_back('{6'b000100, 6'b000000, K_BEQ, 4'b0000}); // beq
      tbl.push_back('{6'b000101, 6'b000000, K_BNE, 4'b0000}); // bne
      tbl.push_back('{6'b000010, 6'b000000, K_J,   4'b0000}); // j
      tbl.push_back('{6'b000011, 6'b000000, K_JAL, 4'b0000}); // jal
      tbl.push_back('{6'b111111, 6'b000000, K_ILL, 4'b0000}); // bad opcode
      tbl.push_back('{6'b000000, 6'b101010, K_ILL, 4'b0000}); // slt without HAS_SLT
      tbl.push_back('{6'b000000, 6'b000001, K_ILL, 4'b0000}); // bad func
      tbl.push_back('{6'b010000, 6'b000000, K_ILL, 4'b0000}); // bad opcode
      slt_ok = '{6'b000000, 6'b101010, K_R, 4'b1011};

      rst = 1'b1; z = 1'b0; mem_ready = 1'b1; op = '0; func = '0;
      rst2 = 1'b1; z2 = 1'b0; mem_ready2 = 1'b0; op2 = '0; func2 = '0;
      @(posedge clk); #1;

      // Held in reset at IF: enables masked even though mem_ready is high.
      o = blank(3'd0); o.alusrcb = 2'b01;
      add_step(1'b1, 1'b1, 1'b0, o);
      run_plan(1'b0);

      issue(tbl[I_ADD],   0, 0, 1'b0, 1'b0);
      issue(tbl[I_LW],    0, 2, 1'b0, 1'b0);
      issue(tbl[I_BEQ],   0, 0, 1'b1, 1'b0);
      issue(tbl[I_BEQ],   0, 0, 1'b0, 1'b0);
      issue(tbl[I_JAL],   0, 0, 1'b0, 1'b0);
      issue(tbl[I_ILLOP], 0, 0, 1'b0, 1'b0);
      issue(tbl[I_SLT],   0, 0, 1'b0, 1'b0);
      issue(tbl[I_SW],    2, 1, 1'b1, 1'b0);

      // sw aborted by reset while waiting in MEM, with mem_ready rising that cycle.
      set_ins(tbl[I_SW], 1'b0);
      model(tbl[I_SW], 0, 2, 1'b0);
      void'(plan.pop_back());
      o = blank(3'd3); o.iord = 1'b1;
      add_step(1'b1, 1'b1, 1'b0, o);
      run_plan(1'b0);

      for (int n = 0; n < 300; n++) begin
         idx = $urandom_range(0, tbl.size() - 1);
         issue(tbl[idx], $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit(), 1'b0);
      end

      // Second instance: mem_ready ignored, slt supported.
      o = blank(3'd0); o.alusrcb = 2'b01;
      add_step(1'b1, 1'b0, 1'b0, o);
      run_plan(1'b1);
      issue(tbl[I_SW], 0, 0, 1'b0, 1'b1);
      issue(tbl[I_LW], 0, 0, 1'b0, 1'b1);
      issue(slt_ok,    0, 0, 1'b0, 1'b1);
      issue(tbl[I_ADD], 0, 0, 1'b0, 1'b1);

      @(negedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mccu_fsm.md
MCCU_FSM -- requirements
Module: mccu_fsm

Interface
REQ-001 Parameter USE_MEM_READY, default 1, meaning: 1 = fetch/memory states wait on mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter HAS_SLT, default 0, meaning: 1 = decode R-type slt (func 101010) with aluc 1011.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 op, func  in  6 each  instruction opcode and function fields, from the instruction register.
REQ-006 z  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access complete this cycle.
REQ-008 wpc, wir, wmem, wreg  out  1 each  write enables: PC, instruction register, data memory, register file.
REQ-009 iord  out  1  memory address: 0 = PC, 1 = ALU result register.
REQ-010 alusrca  out  1  ALU A: 0 = PC, 1 = register A; shift out 1, ALU A = shamt.
REQ-011 alusrcb  out  2  ALU B: 00 = reg B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2.
REQ-012 aluc out 4; pcsrc out 2 (00 ALU, 01 branch target, 10 reg A, 11 jump addr); regrt, m2reg, jal, sext out 1 each.
REQ-013 illegal  out  1  unsupported instruction detected; state  out  3  current FSM state.

Function
REQ-014 aluc codes SHALL be add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
REQ-015 Instruction set SHALL match the single-cycle unit: add sub and or xor sll srl sra jr, addi andi ori xori lw sw beq bne lui, j jal.
REQ-016 States SHALL be IF(000), ID(001), EXE(010), MEM(011), WB(100); other encodings return to IF next cycle.
REQ-017 All outputs are combinational functions of state, op, func, z and mem_ready (Moore plus qualified enables); any output not listed for a state SHALL be 0.
REQ-018 IF: iord=0, alusrca=0, alusrcb=01, aluc=add, pcsrc=00; wpc=wir=mem_ready; advance to ID only when mem_ready, else hold IF.
REQ-019 ID, j: pcsrc=11, wpc=1, go IF; jal: additionally wreg=1, jal=1; jr: pcsrc=10, wpc=1, go IF.
REQ-020 ID, others: alusrca=0, alusrcb=11, aluc=add, sext=1 (branch target to ALU register), go EXE.
REQ-021 ID, illegal op/func: illegal=1 for exactly this cycle, no write enable asserted, go IF.
REQ-022 EXE, beq/bne: alusrca=1, alusrcb=00, aluc=sub, pcsrc=01, wpc=z (beq) or ~z (bne), sext=1, go IF.
REQ-023 EXE, lw/sw: alusrca=1, alusrcb=10, aluc=add, sext=1, go MEM.
REQ-024 EXE, R-type: alusrca=1 (shift=1 for sll/srl/sra), alusrcb=00, aluc per func, go WB.
REQ-025 EXE, I-type ALU: alusrca=1, alusrcb=10, sext=1 only for addi, aluc per op, go WB.
REQ-026 MEM: iord=1; sw: wmem=mem_ready, go IF when mem_ready; lw: go WB when mem_ready; else hold MEM.
REQ-027 WB: wreg=1; regrt=1 for I-type/lw; m2reg=1 for lw; go IF.
REQ-028 CPI SHALL be (zero-wait): j/jal/jr 2, beq/bne 3, R/I ALU 4, sw 4, lw 5.
REQ-029 wmem and wreg SHALL never assert in the same cycle; wpc at most once per instruction.

Reset
REQ-030 rst=1 at a rising edge SHALL force state=IF regardless of current state, including mid-MEM wait; no write enable asserts in the reset cycle.
REQ-031 After reset deasserts, first IF begins in the following cycle; outputs follow REQ-018.

Structure
REQ-032 Package mccu_pkg SHALL hold state encoding, opcode/func constants, aluc codes, alusrcb/pcsrc encodings.
REQ-033 Combinational decode SHALL be sub-module mccu_decode (op, func -> one-hot instruction class, illegal); FSM and output logic in mccu_fsm.

Verification
REQ-034 add (op 000000, func 100000), mem_ready=1 -> states IF,ID,EXE,WB; wreg=1 only in WB, aluc=0000, regrt=0.
REQ-035 lw (op 100011), mem_ready low 2 cycles in MEM -> MEM held 3 cycles, then WB with m2reg=1, regrt=1; total 7 cycles.
REQ-036 beq (op 000100) z=1 -> EXE wpc=1, pcsrc=01; z=0 -> wpc=0; both back to IF after 3 cycles.
REQ-037 jal (op 000011) -> ID asserts wpc=1, wreg=1, jal=1, pcsrc=11; next state IF.
REQ-038 op 111111 -> illegal=1 one cycle in ID, all enables 0, next IF; HAS_SLT=0 with func 101010 -> illegal.
REQ-039 rst=1 during MEM wait of sw -> next state IF, wmem never asserted; USE_MEM_READY=0 with mem_ready=0 -> sw completes in 4 cycles.
